// File: rtl/hazard_control_unit_pkg.sv
// rtl/hazard_control_unit_pkg.sv - shared core defines for the hazard/stall sequencer
package hazard_control_unit_pkg;

  typedef enum logic {
    HZD_IDLE    = 1'b0,
    HZD_MD_BUSY = 1'b1
  } hzd_state_t;

  localparam int MD_MAX_CYCLES_DEF = 40;

endpackage

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use bubble, mul/div freeze and redirect flush sequencer
// Stall/flush enables are combinational so a release lands on the same edge as md_done.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int MD_MAX_CYCLES = MD_MAX_CYCLES_DEF,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [4:0]       rd_ex,
  input  logic             mem_read_ex,
  input  logic             md_valid_ex,
  input  logic             md_done,
  input  logic             redirect_ex,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             md_start,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WD_W = $clog2(MD_MAX_CYCLES + 1);

  hzd_state_t      state;
  logic [WD_W-1:0] wd_cnt;
  logic            lu;
  logic            wd_expire;

  assign lu = mem_read_ex && (rd_ex != 5'd0) &&
              ((rs1_used_id && (rs1_id == rd_ex)) ||
               (rs2_used_id && (rs2_id == rd_ex)));

  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    md_start      = 1'b0;
    wd_expire     = 1'b0;
    if (!rst) begin
      case (state)
        HZD_IDLE: begin
          if (redirect_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (md_valid_ex) begin
            md_start      = 1'b1;
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
          end else if (lu) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        HZD_MD_BUSY: begin
          // Load-use and redirect are masked: EX is occupied by the mul/div op.
          if (md_done) begin
            wd_expire = 1'b0;
          end else if (wd_cnt == WD_W'(MD_MAX_CYCLES)) begin
            wd_expire = 1'b1;
          end else begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
          end
        end
        default: wd_expire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HZD_IDLE;
      wd_cnt       <= '0;
      md_timeout   <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (pc_stall) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      case (state)
        HZD_IDLE: begin
          if (md_start) begin
            state  <= HZD_MD_BUSY;
            wd_cnt <= WD_W'(1);
          end
        end
        HZD_MD_BUSY: begin
          if (md_done || wd_expire) begin
            state  <= HZD_IDLE;
            wd_cnt <= '0;
            if (wd_expire) begin
              md_timeout <= 1'b1;
            end
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: state <= HZD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed self-checking bench for hazard_control_unit
module tb_hazard_control_unit;
  import hazard_control_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic        rs1_used_id;
  logic        rs2_used_id;
  logic [4:0]  rd_ex;
  logic        mem_read_ex;
  logic        md_valid_ex;
  logic        md_done;
  logic        redirect_ex;
  logic        pc_stall;
  logic        if_id_stall;
  logic        id_ex_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_bubble;
  logic        md_start;
  logic        md_timeout;
  logic [31:0] stall_cycles;
  logic [6:0]  outs;

  int checks;
  int errors;

  // {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_bubble, md_start}
  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_LU    = 7'b1100100;
  localparam logic [6:0] O_FLUSH = 7'b0001100;
  localparam logic [6:0] O_START = 7'b1110011;
  localparam logic [6:0] O_BUSY  = 7'b1110010;

  hazard_control_unit #(.MD_MAX_CYCLES(40), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
    .md_valid_ex(md_valid_ex), .md_done(md_done), .redirect_ex(redirect_ex),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_bubble(ex_mem_bubble), .md_start(md_start),
    .md_timeout(md_timeout), .stall_cycles(stall_cycles)
  );

  assign outs = {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_bubble, md_start};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && dut.state == HZD_MD_BUSY)
      assert (!redirect_ex) else $error("redirect_ex asserted while mul/div busy");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_id = 5'd0; rs2_id = 5'd0; rs1_used_id = 1'b0; rs2_used_id = 1'b0;
    rd_ex = 5'd0; mem_read_ex = 1'b0; md_valid_ex = 1'b0; md_done = 1'b0;
    redirect_ex = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    md_valid_ex = 1'b1; redirect_ex = 1'b1; mem_read_ex = 1'b1; rd_ex = 5'd3;
    rs1_id = 5'd3; rs1_used_id = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL reset_outs got %b exp %b", outs, O_NONE);
    end
    next_cycle();
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'd0 || md_timeout !== 1'b0 || outs !== O_NONE) begin
      errors++;
      $display("FAIL reset_state got cnt=%0d to=%b outs=%b exp cnt=0 to=0 outs=%b",
               stall_cycles, md_timeout, outs, O_NONE);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs1_used_id = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_LU) begin
      errors++; $display("FAIL load_use_rs1 got %b exp %b", outs, O_LU);
    end
    next_cycle();
    clear_inputs();
    rs1_id = 5'd5; rs1_used_id = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE || stall_cycles !== 32'd1) begin
      errors++; $display("FAIL load_use_after got outs=%b cnt=%0d exp outs=%b cnt=1",
                         outs, stall_cycles, O_NONE);
    end
    next_cycle();
    clear_inputs();
    mem_read_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd2; rs1_used_id = 1'b1;
    rs2_id = 5'd7; rs2_used_id = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_LU) begin
      errors++; $display("FAIL load_use_rs2 got %b exp %b", outs, O_LU);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_false_hazard();
    do_reset();
    mem_read_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0; rs1_used_id = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL false_rd_x0 got %b exp %b", outs, O_NONE);
    end
    next_cycle();
    clear_inputs();
    mem_read_ex = 1'b1; rd_ex = 5'd9; rs2_id = 5'd9; rs2_used_id = 1'b0; rs1_id = 5'd4; rs1_used_id = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL false_rs2_unused got %b exp %b", outs, O_NONE);
    end
    next_cycle();
    clear_inputs();
    mem_read_ex = 1'b0; rd_ex = 5'd9; rs1_id = 5'd9; rs1_used_id = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE || stall_cycles !== 32'd0) begin
      errors++; $display("FAIL false_not_load got outs=%b cnt=%0d exp outs=%b cnt=0",
                         outs, stall_cycles, O_NONE);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_redirect();
    do_reset();
    redirect_ex = 1'b1; mem_read_ex = 1'b1; rd_ex = 5'd6; rs1_id = 5'd6; rs1_used_id = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_FLUSH) begin
      errors++; $display("FAIL redirect_lu got %b exp %b", outs, O_FLUSH);
    end
    next_cycle();
    clear_inputs();
    redirect_ex = 1'b1; md_valid_ex = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_FLUSH) begin
      errors++; $display("FAIL redirect_md got %b exp %b", outs, O_FLUSH);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (outs !== O_NONE || stall_cycles !== 32'd0) begin
      errors++; $display("FAIL redirect_after got outs=%b cnt=%0d exp outs=%b cnt=0",
                         outs, stall_cycles, O_NONE);
    end
    next_cycle();
  endtask

  task automatic test_divide();
    do_reset();
    md_valid_ex = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_START) begin
      errors++; $display("FAIL divide_start got %b exp %b", outs, O_START);
    end
    next_cycle();
    for (int i = 1; i < 34; i++) begin
      // a load-use pattern in ID must stay masked while busy
      mem_read_ex = (i == 5); rd_ex = 5'd8; rs1_id = 5'd8; rs1_used_id = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== O_BUSY) begin
        errors++; $display("FAIL divide_busy cyc=%0d got %b exp %b", i, outs, O_BUSY);
      end
      next_cycle();
    end
    mem_read_ex = 1'b0;
    md_done = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL divide_done got %b exp %b", outs, O_NONE);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (outs !== O_NONE || stall_cycles !== 32'd34 || md_timeout !== 1'b0) begin
      errors++; $display("FAIL divide_count got outs=%b cnt=%0d to=%b exp outs=%b cnt=34 to=0",
                         outs, stall_cycles, md_timeout, O_NONE);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_seq [6];
    exp_seq = '{O_START, O_BUSY, O_BUSY, O_NONE, O_START, O_NONE};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      md_valid_ex = 1'b1;
      md_done = (i == 3) || (i == 5);
      @(negedge clk);
      checks++;
      if (outs !== exp_seq[i]) begin
        errors++; $display("FAIL back_to_back cyc=%0d got %b exp %b", i, outs, exp_seq[i]);
      end
      next_cycle();
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (outs !== O_NONE || stall_cycles !== 32'd4) begin
      errors++; $display("FAIL back_to_back_count got outs=%b cnt=%0d exp outs=%b cnt=4",
                         outs, stall_cycles, O_NONE);
    end
    next_cycle();
  endtask

  task automatic test_watchdog();
    do_reset();
    md_valid_ex = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== ((i == 0) ? O_START : O_BUSY)) begin
        errors++; $display("FAIL watchdog_hold cyc=%0d got %b", i, outs);
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (outs !== O_NONE || md_timeout !== 1'b0) begin
      errors++; $display("FAIL watchdog_release got outs=%b to=%b exp outs=%b to=0",
                         outs, md_timeout, O_NONE);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (outs !== O_NONE || md_timeout !== 1'b1 || stall_cycles !== 32'd40) begin
      errors++; $display("FAIL watchdog_flag got outs=%b to=%b cnt=%0d exp outs=%b to=1 cnt=40",
                         outs, md_timeout, stall_cycles, O_NONE);
    end
    next_cycle();
    md_valid_ex = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_START || md_timeout !== 1'b1) begin
      errors++; $display("FAIL watchdog_restart got outs=%b to=%b exp outs=%b to=1",
                         outs, md_timeout, O_START);
    end
    next_cycle();
    md_done = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE || md_timeout !== 1'b1) begin
      errors++; $display("FAIL watchdog_sticky got outs=%b to=%b exp outs=%b to=1",
                         outs, md_timeout, O_NONE);
    end
    next_cycle();
    do_reset();
    @(negedge clk);
    checks++;
    if (md_timeout !== 1'b0 || stall_cycles !== 32'd0) begin
      errors++; $display("FAIL watchdog_clear got to=%b cnt=%0d exp to=0 cnt=0",
                         md_timeout, stall_cycles);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    md_valid_ex = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL midbusy_rst_outs got %b exp %b", outs, O_NONE);
    end
    next_cycle();
    rst = 1'b0;
    md_valid_ex = 1'b0; md_done = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE || stall_cycles !== 32'd0 || md_timeout !== 1'b0) begin
      errors++; $display("FAIL midbusy_late_done got outs=%b cnt=%0d to=%b exp outs=%b cnt=0 to=0",
                         outs, stall_cycles, md_timeout, O_NONE);
    end
    next_cycle();
    md_done = 1'b0; md_valid_ex = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_START || stall_cycles !== 32'd0) begin
      errors++; $display("FAIL midbusy_idle got outs=%b cnt=%0d exp outs=%b cnt=0",
                         outs, stall_cycles, O_START);
    end
    next_cycle();
    md_done = 1'b1;
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    rst = 1'b1;
    #1;
    test_reset();
    test_load_use();
    test_false_hazard();
    test_redirect();
    test_divide();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
